// File: rtl/fifo_wr_streamer_pkg.sv
// fifo_wr_streamer_pkg: shared widths and FSM state encoding for the write-side streamer
package fifo_wr_streamer_pkg;
    localparam int DW = 8;
    localparam int CW = 16;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2,
        PAUSE = 2'd3
    } state_t;
endpackage

// File: rtl/fifo_wr_streamer_if.sv
// fifo_wr_streamer_if: upstream valid/ready byte stream with packet framing
interface fifo_wr_streamer_if #(parameter int DW = fifo_wr_streamer_pkg::DW);
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    modport master (output s_valid, s_data, s_last, input s_ready);
    modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/fifo_wr_streamer_skid.sv
// fifo_skid_buf: two-entry register slice (output stage + skid stage) carrying a last flag
module fifo_skid_buf #(parameter int DW = 8) (
    input  logic          wclk,
    input  logic          wrst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          sk_valid
);
    logic          out_v_q, out_v_d, out_last_q, out_last_d;
    logic          sk_v_q, sk_v_d, sk_last_q, sk_last_d, rdy_q, rdy_d;
    logic [DW-1:0] out_d_q, out_d_d, sk_d_q, sk_d_d;
    logic          acc, pop;

    // Accepted bytes go straight to the output stage when it is free or draining, else park in skid;
    // the output data register is only reloaded with new bytes so wdata holds when empty.
    always_comb begin
        acc        = in_valid & rdy_q;
        pop        = out_v_q & out_ready;
        out_v_d    = pop ? sk_v_q : out_v_q;
        out_d_d    = (pop & sk_v_q) ? sk_d_q : out_d_q;
        out_last_d = (pop & sk_v_q) ? sk_last_q : out_last_q;
        sk_v_d     = sk_v_q & ~pop;
        sk_d_d     = sk_d_q;
        sk_last_d  = sk_last_q;
        if (acc & (~out_v_q | pop)) begin
            out_v_d    = 1'b1;
            out_d_d    = in_data;
            out_last_d = in_last;
        end else if (acc) begin
            sk_v_d    = 1'b1;
            sk_d_d    = in_data;
            sk_last_d = in_last;
        end
        rdy_d = ~sk_v_d;
    end

    // Stage registers; ready stays low through reset and rises on the first clock after release
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            out_v_q    <= 1'b0;
            out_d_q    <= '0;
            out_last_q <= 1'b0;
            sk_v_q     <= 1'b0;
            sk_d_q     <= '0;
            sk_last_q  <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            out_v_q    <= out_v_d;
            out_d_q    <= out_d_d;
            out_last_q <= out_last_d;
            sk_v_q     <= sk_v_d;
            sk_d_q     <= sk_d_d;
            sk_last_q  <= sk_last_d;
            rdy_q      <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = out_v_q;
    assign out_data  = out_d_q;
    assign out_last  = out_last_q;
    assign sk_valid  = sk_v_q;
endmodule

// File: rtl/fifo_wr_streamer.sv
// fifo_wr_streamer: feeds the async FIFO write port from a framed byte stream and keeps packet stats
module fifo_wr_streamer #(
    parameter int DW = fifo_wr_streamer_pkg::DW,
    parameter int CW = fifo_wr_streamer_pkg::CW
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 en,
    fifo_wr_streamer_if.slave    s,
    output logic                 winc,
    output logic [DW-1:0]        wdata,
    input  logic                 wfull,
    output logic                 busy,
    output logic                 pkt_done,
    output logic [CW-1:0]        pkt_len,
    output logic [CW-1:0]        pkt_cnt,
    output logic                 len_ovf
);
    import fifo_wr_streamer_pkg::*;

    localparam logic [CW-1:0] LEN_MAX = '1;

    state_t        state_q, state_d;
    logic          out_v, out_last, sk_v, acc, commit, drain;
    logic          done_q, done_d, len_ovf_q, len_ovf_d;
    logic [CW-1:0] cur_len_q, cur_len_d, cur_inc, pkt_len_q, pkt_len_d, pkt_cnt_q, pkt_cnt_d;

    fifo_skid_buf #(.DW(DW)) u_buf (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .in_valid  (s.s_valid),
        .in_data   (s.s_data),
        .in_last   (s.s_last),
        .in_ready  (s.s_ready),
        .out_valid (out_v),
        .out_data  (wdata),
        .out_last  (out_last),
        .out_ready (en & ~wfull),
        .sk_valid  (sk_v)
    );

    assign winc   = out_v & en;
    assign commit = winc & ~wfull;
    assign acc    = s.s_valid & s.s_ready;
    assign busy   = out_v | sk_v;

    // Next state: IDLE exactly when the output stage will be empty; otherwise en beats wfull
    always_comb begin
        drain   = commit & ~sk_v & ~acc;
        state_d = (state_q == IDLE) ? (acc ? SEND : IDLE) :
                  drain ? IDLE : !en ? PAUSE : wfull ? STALL : SEND;
    end

    // Packet statistics: length saturates, count wraps, overflow is sticky until reset
    always_comb begin
        cur_inc   = (cur_len_q == LEN_MAX) ? LEN_MAX : cur_len_q + 1'b1;
        done_d    = commit & out_last;
        cur_len_d = commit ? (out_last ? '0 : cur_inc) : cur_len_q;
        pkt_len_d = done_d ? cur_inc : pkt_len_q;
        pkt_cnt_d = done_d ? pkt_cnt_q + 1'b1 : pkt_cnt_q;
        len_ovf_d = len_ovf_q | (commit & (cur_len_q == LEN_MAX));
    end

    // State and statistics registers
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q   <= IDLE;
            cur_len_q <= '0;
            done_q    <= 1'b0;
            pkt_len_q <= '0;
            pkt_cnt_q <= '0;
            len_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_len_q <= cur_len_d;
            done_q    <= done_d;
            pkt_len_q <= pkt_len_d;
            pkt_cnt_q <= pkt_cnt_d;
            len_ovf_q <= len_ovf_d;
        end
    end

    assign pkt_done = done_q;
    assign pkt_len  = pkt_len_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign len_ovf  = len_ovf_q;

    // The FSM label must track output-stage occupancy
    assert property (@(posedge wclk) disable iff (!wrst_n) (state_q == IDLE) == !out_v);
endmodule

// File: tb/tb_fifo_wr_streamer.sv
// tb_fifo_wr_streamer: randomized stimulus against a queue-based packet model
module tb_fifo_wr_streamer;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int LMAX = 15;

    logic          wclk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          en = 1'b0;
    logic          wfull = 1'b0;
    logic          winc, busy, pkt_done, len_ovf;
    logic [DW-1:0] wdata;
    logic [CW-1:0] pkt_len, pkt_cnt;

    fifo_wr_streamer_if #(.DW(DW)) s_if ();

    fifo_wr_streamer #(.DW(DW), .CW(CW)) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .en       (en),
        .s        (s_if),
        .winc     (winc),
        .wdata    (wdata),
        .wfull    (wfull),
        .busy     (busy),
        .pkt_done (pkt_done),
        .pkt_len  (pkt_len),
        .pkt_cnt  (pkt_cnt),
        .len_ovf  (len_ovf)
    );

    always #5 wclk = ~wclk;

    int         n_cmp = 0, n_err = 0;
    logic [8:0] tx[$];
    logic [8:0] q[$];
    int         cur_len = 0, m_len = 0, m_cnt = 0, m_commits = 0;
    bit         m_ovf = 0, m_done = 0, hold = 0, dense = 0, saw_nrdy = 0;
    logic [7:0] m_wdata = 8'h00;
    int         dut_commits = 0, dut_dones = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_pkt(input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) tx.push_back({i == len - 1, 8'(base + 8'(i))});
    endtask

    task automatic cycle(input bit e, input bit f);
        bit         acc, cmt, rdy, wi;
        logic [8:0] b;
        @(posedge wclk);
        #1;
        en = e;
        wfull = f;
        s_if.s_valid = tx.size() > 0 && (hold || dense || $urandom_range(0, 3) != 0);
        if (tx.size() > 0) {s_if.s_last, s_if.s_data} = tx[0];
        @(negedge wclk);
        rdy = q.size() < 2;
        wi  = q.size() > 0 && e;
        check("winc", winc, wi);
        check("wdata", wdata, q.size() > 0 ? q[0][7:0] : m_wdata);
        check("busy", busy, q.size() > 0);
        check("s_ready", s_if.s_ready, rdy);
        check("pkt_done", pkt_done, m_done);
        check("pkt_len", pkt_len, m_len);
        check("pkt_cnt", pkt_cnt, m_cnt);
        check("len_ovf", len_ovf, m_ovf);
        if (winc && !wfull) dut_commits++;
        if (pkt_done) dut_dones++;
        if (!s_if.s_ready) saw_nrdy = 1;
        acc = s_if.s_valid && rdy;
        cmt = wi && !f;
        hold = s_if.s_valid && !acc;
        m_done = 0;
        if (cmt) begin
            b = q.pop_front();
            m_commits++;
            cur_len++;
            if (cur_len > LMAX) m_ovf = 1;
            if (b[8]) begin
                m_done = 1;
                m_len = cur_len > LMAX ? LMAX : cur_len;
                m_cnt = (m_cnt + 1) % (LMAX + 1);
                cur_len = 0;
            end
        end
        if (acc) q.push_back(tx.pop_front());
        if (q.size() > 0) m_wdata = q[0][7:0];
    endtask

    task automatic drain(input int max);
        for (int n = 0; n < max && (tx.size() > 0 || q.size() > 0); n++) cycle(1, 0);
        cycle(1, 0);
        cycle(1, 0);
    endtask

    task automatic do_reset();
        @(posedge wclk);
        #2;
        wrst_n = 1'b0;
        s_if.s_valid = 1'b0;
        #1;
        check("rst_winc", winc, 0);
        check("rst_wdata", wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", pkt_done, 0);
        check("rst_len", pkt_len, 0);
        check("rst_cnt", pkt_cnt, 0);
        check("rst_ovf", len_ovf, 0);
        check("rst_rdy", s_if.s_ready, 0);
        tx.delete();
        q.delete();
        cur_len = 0; m_len = 0; m_cnt = 0; m_ovf = 0; m_done = 0; m_wdata = 8'h00; hold = 0;
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        #1;
        check("rel_rdy", s_if.s_ready, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int st, base;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        s_if.s_last  = 1'b0;
        do_reset();

        // back-to-back 4-byte packet
        dense = 1;
        dut_commits = 0;
        add_pkt(4, 8'hA0);
        drain(50);
        check("t1_len", pkt_len, 4);
        check("t1_cnt", pkt_cnt, 1);
        check("t1_commits", dut_commits, 4);
        check("t1_dones", dut_dones, 1);

        // wfull stall for 3 cycles after the second commit
        dut_commits = 0;
        saw_nrdy = 0;
        base = m_commits;
        st = 0;
        add_pkt(8, 8'h10);
        add_pkt(8, 8'h18);
        for (int c = 0; c < 200 && (tx.size() > 0 || q.size() > 0); c++) begin
            bit f;
            f = (m_commits - base >= 2) && st < 3;
            if (f) st++;
            cycle(1, f);
            if (f) begin
                check("t2_hold_wdata", wdata, 8'h12);
                check("t2_hold_winc", winc, 1);
            end
        end
        drain(50);
        check("t2_commits", dut_commits, 16);
        check("t2_nrdy", saw_nrdy, 1);
        check("t2_len", pkt_len, 8);
        check("t2_cnt", pkt_cnt, 3);

        // en low for 5 cycles mid-packet
        base = m_commits;
        st = 0;
        add_pkt(10, 8'h30);
        for (int c = 0; c < 200 && (tx.size() > 0 || q.size() > 0); c++) begin
            bit e;
            e = !((m_commits - base >= 4) && st < 5);
            if (!e) st++;
            cycle(e, 0);
            if (!e) begin
                check("t3_winc", winc, 0);
                check("t3_wdata", wdata, 8'h34);
            end
        end
        drain(50);
        check("t3_len", pkt_len, 10);
        check("t3_cnt", pkt_cnt, 4);

        // over-long packet saturates the length
        dense = 0;
        add_pkt(20, 8'h40);
        drain(200);
        check("t4_len", pkt_len, LMAX);
        check("t4_ovf", len_ovf, 1);
        add_pkt(3, 8'h58);
        drain(50);
        check("t4_ovf_sticky", len_ovf, 1);
        check("t4_len2", pkt_len, 3);

        // 17 one-byte packets wrap the counter
        do_reset();
        dut_dones = 0;
        for (int i = 0; i < LMAX + 2; i++) add_pkt(1, 8'(8'h80 + 8'(i)));
        drain(300);
        check("t5_dones", dut_dones, LMAX + 2);
        check("t5_cnt", pkt_cnt, 1);

        // reset with two bytes buffered mid-packet
        dense = 1;
        add_pkt(5, 8'h60);
        for (int c = 0; c < 10 && q.size() < 2; c++) cycle(1, 1);
        check("t6_busy", busy, 1);
        do_reset();
        add_pkt(3, 8'h70);
        drain(50);
        check("t6_len", pkt_len, 3);
        check("t6_cnt", pkt_cnt, 1);
        check("t6_ovf", len_ovf, 0);

        // random traffic with random en and wfull
        dense = 0;
        for (int p = 0; p < 40; p++) add_pkt($urandom_range(1, 20), 8'($urandom));
        for (int c = 0; c < 4000 && (tx.size() > 0 || q.size() > 0); c++)
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0);
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
